aes_core_ctrl: RTL and testbench

Top-level sequencer for the AES core. It accepts host init/next commands and drives key expansion in the key memory, then runs encipher or decipher on the shared round datapath. It owns the single shared S-box, steering it to the key memory during expansion and to the encipher block otherwise. It sits between the host register interface and aes_key_mem, aes_encipher_block and aes_decipher_block.

---
 rtl/aes_ctrl_pkg.sv | 25 ++
 rtl/aes_ctrl_watchdog.sv | 34 +++
 rtl/aes_core_ctrl.sv | 161 ++++++++++++++++
 tb/tb_aes_core_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared constants for the AES core controller: FSM state encodings,
// key-length and direction codes, and the default watchdog depth.
package aes_ctrl_pkg;

    // 3-bit FSM encodings; 3'd7 is unused and recovers to IDLE
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] KEY_START = 3'd1;
    localparam logic [2:0] KEY_WAIT  = 3'd2;
    localparam logic [2:0] ENC_START = 3'd3;
    localparam logic [2:0] ENC_WAIT  = 3'd4;
    localparam logic [2:0] DEC_START = 3'd5;
    localparam logic [2:0] DEC_WAIT  = 3'd6;

    // Key length select as seen by the key memory
    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    // Direction select, also the polarity of the result mux select
    localparam logic ENCDEC_DEC = 1'b0;
    localparam logic ENCDEC_ENC = 1'b1;

    // Watchdog depth in WAIT cycles when no override is given
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/aes_ctrl_watchdog.sv
// Watchdog for the controller WAIT states. Only compiled when
// AES_CTRL_TIMEOUT_EN is defined, since it is only instantiated then.
// clear zeroes the count, start lets it advance one step per cycle,
// expire flags the cycle on which the count reaches TIMEOUT_CYCLES-1.
`ifdef AES_CTRL_TIMEOUT_EN
module aes_ctrl_watchdog
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expire
);

    logic [7:0] count;

    // Count WAIT cycles, restarting from zero each time a WAIT state is entered
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (start) begin
            count <= count + 8'd1;
        end
    end

    assign expire = start && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/aes_core_ctrl.sv
// Top-level sequencer for the AES core: runs key expansion on init and one
// encipher/decipher block on next, and steers the shared S-box.
// Optional watchdog on WAIT states enabled by defining AES_CTRL_TIMEOUT_EN.
module aes_core_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        next,
    input  logic        encdec,
    input  logic        keylen,
    output logic        key_init,
    input  logic        key_ready,
    output logic        key_keylen,
    output logic        enc_next,
    input  logic        enc_ready,
    output logic        dec_next,
    input  logic        dec_ready,
    input  logic [31:0] keymem_sboxw,
    input  logic [31:0] enc_sboxw,
    output logic [31:0] sboxw,
    output logic        ready,
    output logic        key_valid,
    output logic        result_valid,
    output logic        encdec_sel,
    output logic        timeout_err
);

    logic [2:0] state;
    logic       armed;
    logic       wait_state;
    logic       start_state;
    logic       target_ready;
    logic       done;
    logic       expire;

    if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("aes_core_ctrl: TIMEOUT_CYCLES must be within 16..255");
    end

    // Start pulses are pure decodes of the state register
    assign key_init = (state == KEY_START);
    assign enc_next = (state == ENC_START);
    assign dec_next = (state == DEC_START);

    // Classify the state and pick the ready line of the block being waited on
    always_comb begin
        wait_state   = (state == KEY_WAIT) || (state == ENC_WAIT) || (state == DEC_WAIT);
        start_state  = key_init || enc_next || dec_next;
        target_ready = 1'b1;
        case (state)
            KEY_START, KEY_WAIT: target_ready = key_ready;
            ENC_START, ENC_WAIT: target_ready = enc_ready;
            DEC_START, DEC_WAIT: target_ready = dec_ready;
            default:             target_ready = 1'b1;
        endcase
        done = wait_state && armed && target_ready;
    end

    // S-box belongs to the key memory only while key expansion is in flight
    always_comb begin
        sboxw = enc_sboxw;
        if ((state == KEY_START) || (state == KEY_WAIT)) begin
            sboxw = keymem_sboxw;
        end
    end

`ifdef AES_CTRL_TIMEOUT_EN
    aes_ctrl_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .start  (wait_state),
        .clear  (start_state),
        .expire (expire)
    );

    // Sticky abort flag, cleared only by reset or a freshly accepted init
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if ((state == IDLE) && init) begin
            timeout_err <= 1'b0;
        end else if (expire && !done) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Command sequencer: accept commands in IDLE, pulse the target, then wait
    // for its ready to drop and come back (armed) before reporting completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ready        <= 1'b1;
            key_valid    <= 1'b0;
            result_valid <= 1'b0;
            key_keylen   <= AES_128_BIT_KEY;
            encdec_sel   <= ENCDEC_ENC;
            armed        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        key_keylen   <= keylen;
                        key_valid    <= 1'b0;
                        result_valid <= 1'b0;
                        ready        <= 1'b0;
                        state        <= KEY_START;
                    end else if (next && key_valid) begin
                        encdec_sel   <= encdec;
                        result_valid <= 1'b0;
                        ready        <= 1'b0;
                        state        <= (encdec == ENCDEC_ENC) ? ENC_START : DEC_START;
                    end
                end
                KEY_START: begin
                    armed <= 1'b0;
                    state <= KEY_WAIT;
                end
                ENC_START: begin
                    armed <= 1'b0;
                    state <= ENC_WAIT;
                end
                DEC_START: begin
                    armed <= 1'b0;
                    state <= DEC_WAIT;
                end
                KEY_WAIT, ENC_WAIT, DEC_WAIT: begin
                    if (!target_ready) begin
                        armed <= 1'b1;
                    end
                    if (done) begin
                        if (state == KEY_WAIT) begin
                            key_valid <= 1'b1;
                        end else begin
                            result_valid <= 1'b1;
                        end
                        ready <= 1'b1;
                        state <= IDLE;
                    end else if (expire) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Self-checking bench for aes_core_ctrl. Behavioural stubs stand in for the
// key memory and round blocks; expectations come from a transaction-level
// model of the controller's observable behaviour.
module tb_aes_core_ctrl;

    localparam int TB_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset, init, next, encdec, keylen;
    logic        key_init, key_ready, key_keylen;
    logic        enc_next, enc_ready, dec_next, dec_ready;
    logic [31:0] keymem_sboxw, enc_sboxw, sboxw;
    logic        ready, key_valid, result_valid, encdec_sel, timeout_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Model of architectural flags
    logic m_key_valid, m_result_valid, m_keylen, m_encdec_sel, m_timeout;

    // Stub controls
    int   key_busy = 1, enc_busy = 1, dec_busy = 1;
    int   key_cnt, enc_cnt, dec_cnt;
    logic enc_hold = 1'b0;

    always #5 clk = ~clk;

    aes_core_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .init(init), .next(next), .encdec(encdec),
        .keylen(keylen), .key_init(key_init), .key_ready(key_ready),
        .key_keylen(key_keylen), .enc_next(enc_next), .enc_ready(enc_ready),
        .dec_next(dec_next), .dec_ready(dec_ready), .keymem_sboxw(keymem_sboxw),
        .enc_sboxw(enc_sboxw), .sboxw(sboxw), .ready(ready), .key_valid(key_valid),
        .result_valid(result_valid), .encdec_sel(encdec_sel), .timeout_err(timeout_err)
    );

    // Downstream stubs: registered ready drops after the start pulse and
    // returns after the configured number of busy cycles
    always @(posedge clk) begin
        if (reset) begin
            key_ready <= 1'b1; key_cnt <= 0;
            enc_ready <= 1'b1; enc_cnt <= 0;
            dec_ready <= 1'b1; dec_cnt <= 0;
        end else begin
            if (key_init) begin
                key_ready <= 1'b0; key_cnt <= key_busy;
            end else if (key_cnt > 0) begin
                key_cnt <= key_cnt - 1;
                if (key_cnt == 1) key_ready <= 1'b1;
            end
            if (enc_next && !enc_hold) begin
                enc_ready <= 1'b0; enc_cnt <= enc_busy;
            end else if (enc_cnt > 0) begin
                enc_cnt <= enc_cnt - 1;
                if (enc_cnt == 1) enc_ready <= 1'b1;
            end
            if (dec_next) begin
                dec_ready <= 1'b0; dec_cnt <= dec_busy;
            end else if (dec_cnt > 0) begin
                dec_cnt <= dec_cnt - 1;
                if (dec_cnt == 1) dec_ready <= 1'b1;
            end
        end
    end

    task automatic model_reset();
        m_key_valid = 1'b0; m_result_valid = 1'b0; m_keylen = 1'b0;
        m_encdec_sel = 1'b1; m_timeout = 1'b0;
    endtask

    // Issue a command (from just after a negedge) and follow it to completion
    task automatic run_op(input string name, input logic do_init, input logic do_next,
                          input logic kl, input logic ed, input int busy, input int next_at);
        int kind, c, rise, n_key, n_enc, n_dec, first_pulse, sbox_bad, ready_bad;
        logic seen_low, tgt, exp_ready, fin;
        logic [31:0] exp_sbox;
        kind = do_init ? 1 : ((do_next && m_key_valid) ? (ed ? 2 : 3) : 0);
        key_busy = busy; enc_busy = busy; dec_busy = busy;
        init = do_init; next = do_next; keylen = kl; encdec = ed;
        c = 0; rise = 0; seen_low = 1'b0; fin = 1'b0;
        n_key = 0; n_enc = 0; n_dec = 0; first_pulse = 0; sbox_bad = 0; ready_bad = 0;
        while (!fin && c < 400) begin
            @(negedge clk);
            c++;
            if (key_init) begin n_key++; if (first_pulse == 0) first_pulse = c; end
            if (enc_next) begin n_enc++; if (first_pulse == 0) first_pulse = c; end
            if (dec_next) begin n_dec++; if (first_pulse == 0) first_pulse = c; end
            case (kind)
                1:       tgt = key_ready;
                2:       tgt = enc_ready;
                3:       tgt = dec_ready;
                default: tgt = 1'b1;
            endcase
            if (kind != 0) begin
                if (!tgt) seen_low = 1'b1;
                else if (seen_low && rise == 0) rise = c;
            end
            exp_ready = (kind == 0) ? 1'b1 : (rise != 0 && c > rise);
            if (ready !== exp_ready) ready_bad++;
            if (c == 1 && kind == 1) begin
                tests_run++;
                if (key_valid !== 1'b0 || result_valid !== 1'b0 || key_keylen !== kl) begin
                    tests_failed++;
                    $display("[TB] FAIL %s accept_init: kv/rv/keylen=%b%b%b expected 00%b",
                             name, key_valid, result_valid, key_keylen, kl);
                end
            end
            if (c == 1 && kind >= 2) begin
                tests_run++;
                if (result_valid !== 1'b0 || encdec_sel !== ed) begin
                    tests_failed++;
                    $display("[TB] FAIL %s accept_next: rv/sel=%b%b expected 0%b",
                             name, result_valid, encdec_sel, ed);
                end
            end
            fin = (kind == 0) ? (c >= 6) : (rise != 0 && c == rise + 1);
            init = 1'b0;
            next = (c == next_at) && !fin;
            keylen = 1'($urandom); encdec = 1'($urandom);
            keymem_sboxw = $urandom; enc_sboxw = $urandom;
            #1;
            exp_sbox = (kind == 1 && (rise == 0 || c <= rise)) ? keymem_sboxw : enc_sboxw;
            if (sboxw !== exp_sbox) sbox_bad++;
        end
        repeat (2) begin
            @(negedge clk);
            if (key_init) n_key++;
            if (enc_next) n_enc++;
            if (dec_next) n_dec++;
        end
        tests_run++;
        if (!fin) begin
            tests_failed++;
            $display("[TB] FAIL %s completion: none after %0d cycles, expected ready return", name, c);
        end
        tests_run++;
        if (ready_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s ready_timing: %0d wrong cycles, expected 0", name, ready_bad);
        end
        tests_run++;
        if (sbox_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s sbox_mux: %0d wrong cycles, expected 0", name, sbox_bad);
        end
        tests_run++;
        if (n_key != (kind == 1) || n_enc != (kind == 2) || n_dec != (kind == 3) ||
            first_pulse != ((kind != 0) ? 1 : 0)) begin
            tests_failed++;
            $display("[TB] FAIL %s pulses: key/enc/dec=%0d/%0d/%0d first=%0d expected %0d/%0d/%0d first=%0d",
                     name, n_key, n_enc, n_dec, first_pulse, kind == 1, kind == 2, kind == 3,
                     (kind != 0) ? 1 : 0);
        end
        if (kind == 1) begin
            m_key_valid = 1'b1; m_result_valid = 1'b0; m_keylen = kl; m_timeout = 1'b0;
        end else if (kind != 0) begin
            m_result_valid = 1'b1; m_encdec_sel = ed;
        end
        tests_run++;
        if (key_valid !== m_key_valid || result_valid !== m_result_valid ||
            key_keylen !== m_keylen || encdec_sel !== m_encdec_sel || timeout_err !== m_timeout) begin
            tests_failed++;
            $display("[TB] FAIL %s flags: kv/rv/kl/sel/to=%b%b%b%b%b expected %b%b%b%b%b", name,
                     key_valid, result_valid, key_keylen, encdec_sel, timeout_err,
                     m_key_valid, m_result_valid, m_keylen, m_encdec_sel, m_timeout);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        keymem_sboxw = 32'h1234_5678; enc_sboxw = 32'h9abc_def0;
        #1;
        model_reset();
        tests_run++;
        if (ready !== 1'b1 || key_valid !== 1'b0 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: ready/kv/rv=%b%b%b expected 100", ready, key_valid, result_valid);
        end
        tests_run++;
        if (key_keylen !== 1'b0 || encdec_sel !== 1'b1 || timeout_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_latches: kl/sel/to=%b%b%b expected 010", key_keylen, encdec_sel, timeout_err);
        end
        tests_run++;
        if ({key_init, enc_next, dec_next} !== 3'b000 || sboxw !== enc_sboxw) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: pulses=%b sboxw=%h expected 000 %h",
                     {key_init, enc_next, dec_next}, sboxw, enc_sboxw);
        end
        reset = 1'b0;
    endtask

    task automatic test_next_without_key();
        run_op("next_without_key", 1'b0, 1'b1, 1'b0, 1'b1, 5, 0);
    endtask

    task automatic test_key_expansion();
        run_op("key_expansion", 1'b1, 1'b0, 1'b1, 1'b0, 20, 0);
    endtask

    task automatic test_encipher();
        enc_sboxw = 32'hdeadbeef; keymem_sboxw = 32'h0badf00d;
        #1;
        tests_run++;
        if (sboxw !== 32'hdeadbeef) begin
            tests_failed++;
            $display("[TB] FAIL sbox_passthrough: sboxw=%h expected deadbeef", sboxw);
        end
        run_op("encipher", 1'b0, 1'b1, 1'b0, 1'b1, 42, 0);
    endtask

    task automatic test_decipher();
        run_op("decipher", 1'b0, 1'b1, 1'b0, 1'b0, 42, 0);
    endtask

    task automatic test_contention();
        run_op("init_and_next", 1'b1, 1'b1, 1'b0, 1'b1, 15, 6);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            run_op("random", sel == 0 || sel == 2, sel != 0, 1'($urandom), 1'($urandom),
                   $urandom_range(1, 30), ($urandom_range(0, 1) == 1) ? 2 : 0);
        end
    endtask

    task automatic test_reset_mid_run();
        enc_busy = 42;
        next = 1'b1; encdec = 1'b1;
        repeat (6) begin
            @(negedge clk);
            next = 1'b0;
        end
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_busy: ready=%b expected 0", ready);
        end
        reset = 1'b1;
        @(negedge clk);
        enc_sboxw = $urandom; keymem_sboxw = $urandom;
        #1;
        model_reset();
        tests_run++;
        if (ready !== 1'b1 || key_valid !== 1'b0 || result_valid !== 1'b0 ||
            {key_init, enc_next, dec_next} !== 3'b000 || sboxw !== enc_sboxw) begin
            tests_failed++;
            $display("[TB] FAIL midrun_reset: ready/kv/rv=%b%b%b pulses=%b sbox_ok=%b expected 100 000 1",
                     ready, key_valid, result_valid, {key_init, enc_next, dec_next}, sboxw === enc_sboxw);
        end
        reset = 1'b0;
    endtask

    task automatic test_watchdog();
        int c, first_ready, n_enc;
        enc_hold = 1'b1;
        next = 1'b1; encdec = 1'b1;
        c = 0; first_ready = 0; n_enc = 0;
        while (c < TB_TIMEOUT + 20 && first_ready == 0) begin
            @(negedge clk);
            c++;
            next = 1'b0;
            if (enc_next) n_enc++;
            if (ready) first_ready = c;
        end
        tests_run++;
        if (n_enc != 1) begin
            tests_failed++;
            $display("[TB] FAIL watchdog_pulse: enc_next count=%0d expected 1", n_enc);
        end
`ifdef AES_CTRL_TIMEOUT_EN
        m_timeout = 1'b1; m_result_valid = 1'b0;
        tests_run++;
        if (first_ready != TB_TIMEOUT + 2) begin
            tests_failed++;
            $display("[TB] FAIL watchdog_abort: ready at cycle %0d expected %0d", first_ready, TB_TIMEOUT + 2);
        end
        tests_run++;
        if (timeout_err !== 1'b1 || result_valid !== 1'b0 || key_valid !== m_key_valid) begin
            tests_failed++;
            $display("[TB] FAIL watchdog_flags: to/rv/kv=%b%b%b expected 10%b",
                     timeout_err, result_valid, key_valid, m_key_valid);
        end
`else
        tests_run++;
        if (first_ready != 0 || timeout_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL watchdog_disabled: ready at cycle %0d to=%b expected never 0",
                     first_ready, timeout_err);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
`endif
        enc_hold = 1'b0;
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; next = 1'b0; encdec = 1'b0; keylen = 1'b0;
        keymem_sboxw = 32'h0; enc_sboxw = 32'h0;
        model_reset();
        test_reset();
        test_next_without_key();
        test_key_expansion();
        test_encipher();
        test_decipher();
        test_contention();
        test_random();
        test_reset_mid_run();
        test_next_without_key();
        test_key_expansion();
        test_watchdog();
        test_key_expansion();
        test_encipher();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
